// File: rtl/reflet_int_conditioner_pkg.sv
// Shared constants and types for the Reflet external interrupt conditioner.
package reflet_int_conditioner_pkg;

    localparam int unsigned num_lines = 4;
    localparam int unsigned addr_w    = 2;

    // Register addresses on the configuration port
    localparam logic [addr_w-1:0] cond_mode  = 2'd0;
    localparam logic [addr_w-1:0] cond_pol   = 2'd1;
    localparam logic [addr_w-1:0] cond_pend  = 2'd2;
    localparam logic [addr_w-1:0] cond_force = 2'd3;

    typedef struct packed {
        logic [num_lines-1:0] mode;
        logic [num_lines-1:0] pol;
    } cond_cfg_t;

    function automatic logic [num_lines-1:0] rise_of(
        input logic [num_lines-1:0] s,
        input logic [num_lines-1:0] h
    );
        return s & ~h;
    endfunction

endpackage

// File: rtl/reflet_sync.sv
// Single-bit synchroniser chain with asynchronous active-high reset.
module reflet_sync #(
    parameter int unsigned stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [stages-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[stages-2:0], d};
    end

    assign q = chain[stages-1];

endmodule

// File: rtl/reflet_int_conditioner.sv
// Synchronises, polarity-corrects and level/edge-conditions four external
// interrupt lines ahead of the Reflet interrupt controller.
module reflet_int_conditioner
    import reflet_int_conditioner_pkg::*;
#(
    parameter int unsigned wordsize    = 16,
    parameter int unsigned sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           irq_in,
    input  logic                 ack_valid,
    input  logic [1:0]           ack_id,
    input  logic [1:0]           cfg_addr,
    input  logic                 cfg_write,
    input  logic                 cfg_read,
    input  logic [wordsize-1:0]  cfg_wdata,
    output logic [wordsize-1:0]  cfg_rdata,
    output logic [3:0]           ext_int
);

    logic [num_lines-1:0] sync_q;
    cond_cfg_t            cfg_q;
    logic [num_lines-1:0] pend_q, hist_q, ext_q;
    logic [wordsize-1:0]  rdata_q;

    logic                 wr_mode, wr_pol, wr_pend, wr_force;
    logic [num_lines-1:0] wdata4, mode_n, pol_n, mode_chg;
    logic [num_lines-1:0] s, rise, force_bits, w1c_bits, ack_bits;
    logic [num_lines-1:0] pend_n, ext_n, hist_n;
    logic [num_lines-1:0] rd_mux;
    logic                 unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Config write decode and next register values
    always_comb begin
        wr_mode    = cfg_write && (cfg_addr == cond_mode);
        wr_pol     = cfg_write && (cfg_addr == cond_pol);
        wr_pend    = cfg_write && (cfg_addr == cond_pend);
        wr_force   = cfg_write && (cfg_addr == cond_force);
        wdata4     = cfg_wdata[num_lines-1:0];
        mode_n     = wr_mode ? wdata4 : cfg_q.mode;
        pol_n      = wr_pol ? wdata4 : cfg_q.pol;
        mode_chg   = cfg_q.mode ^ mode_n;
        force_bits = wr_force ? wdata4 : '0;
        w1c_bits   = wr_pend ? wdata4 : '0;
        s          = sync_q ^ cfg_q.pol;
        rise       = rise_of(s, hist_q);
    end

    // Polarity/mode writes re-seed history so the change itself is not an edge
    always_comb begin
        hist_n = hist_q;
        if (wr_mode || wr_pol) hist_n = sync_q ^ pol_n;
        else if (enable)       hist_n = s;
    end

    for (genvar i = 0; i < int'(num_lines); i++) begin : g_line
        logic set_c, clr_c;

        reflet_sync #(.stages(sync_stages)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (irq_in[i]),
            .q     (sync_q[i])
        );

        assign ack_bits[i] = ack_valid && (ack_id == 2'(i));
        assign set_c       = rise[i] | force_bits[i];
        assign clr_c       = w1c_bits[i] | ack_bits[i];

        // Set beats clear; level-mode lines and mode changes force pending low
        assign pend_n[i] = enable
            ? (((pend_q[i] & ~clr_c) | set_c) & cfg_q.mode[i] & ~mode_chg[i])
            : (pend_q[i] & ~mode_chg[i]);

        assign ext_n[i] = enable ? (mode_n[i] ? pend_n[i] : s[i]) : ext_q[i];
    end

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            cond_mode: rd_mux = cfg_q.mode;
            cond_pol:  rd_mux = cfg_q.pol;
            cond_pend: rd_mux = pend_q;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q   <= '0;
            pend_q  <= '0;
            hist_q  <= '0;
            ext_q   <= '0;
            rdata_q <= '0;
        end else begin
            cfg_q.mode <= mode_n;
            cfg_q.pol  <= pol_n;
            pend_q     <= pend_n;
            hist_q     <= hist_n;
            ext_q      <= ext_n;
            rdata_q    <= cfg_read ? wordsize'(rd_mux) : '0;
        end
    end

    assign ext_int   = ext_q;
    assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_reflet_int_conditioner.sv
// Directed bench for reflet_int_conditioner with hand-computed expectations.
module tb_reflet_int_conditioner;

    localparam logic [1:0] a_mode  = 2'd0;
    localparam logic [1:0] a_pol   = 2'd1;
    localparam logic [1:0] a_pend  = 2'd2;
    localparam logic [1:0] a_force = 2'd3;

    logic        clk = 1'b0;
    logic        reset, enable, ack_valid, cfg_write, cfg_read;
    logic [3:0]  irq_in, ext_int;
    logic [1:0]  ack_id, cfg_addr;
    logic [15:0] cfg_wdata, cfg_rdata;

    int checks   = 0;
    int failures = 0;

    reflet_int_conditioner #(.wordsize(16), .sync_stages(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .irq_in    (irq_in),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .cfg_addr  (cfg_addr),
        .cfg_write (cfg_write),
        .cfg_read  (cfg_read),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ext_int   (ext_int)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        cfg_write = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] a);
        cfg_read = 1'b1;
        cfg_addr = a;
        tick();
        cfg_read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; irq_in = '0; ack_valid = 1'b0; ack_id = '0;
        cfg_addr = '0; cfg_write = 1'b0; cfg_read = 1'b0; cfg_wdata = '0;
        tick(); tick();
        check("reset_ext", 16'(ext_int), 16'h0000);
        check("reset_rdata", cfg_rdata, 16'h0000);
        reset = 1'b0;
        tick();

        // Level mode: 3-cycle latency both ways
        irq_in = 4'b0010;
        tick(); tick();
        check("lvl_rise_early", 16'(ext_int), 16'h0000);
        tick();
        check("lvl_rise", 16'(ext_int), 16'h0002);
        irq_in = 4'b0000;
        tick(); tick();
        check("lvl_fall_early", 16'(ext_int), 16'h0002);
        tick();
        check("lvl_fall", 16'(ext_int), 16'h0000);

        // Edge mode: single-cycle pulse captured, then acked
        cfg_wr(a_mode, 16'h0001);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        check("edge_early", 16'(ext_int), 16'h0000);
        tick();
        check("edge_set", 16'(ext_int), 16'h0001);
        repeat (3) tick();
        check("edge_sticky", 16'(ext_int), 16'h0001);
        ack_valid = 1'b1; ack_id = 2'd0;
        tick();
        ack_valid = 1'b0;
        check("ack_clear", 16'(ext_int), 16'h0000);

        // Active-low edge line, read and W1C
        cfg_wr(a_mode, 16'h0008);
        cfg_wr(a_pol, 16'h0008);
        irq_in = 4'b1000;
        repeat (3) tick();
        check("pol_no_edge", 16'(ext_int), 16'h0000);
        irq_in = 4'b0000;
        tick(); tick();
        check("pol_edge_early", 16'(ext_int), 16'h0000);
        tick();
        check("pol_edge", 16'(ext_int), 16'h0008);
        cfg_rd(a_pend);
        check("rd_pend", cfg_rdata, 16'h0008);
        tick();
        check("rdata_idle", cfg_rdata, 16'h0000);
        cfg_wr(a_pend, 16'h0008);
        check("w1c_clear", 16'(ext_int), 16'h0000);

        // Set beats ack and W1C on line 2
        cfg_wr(a_pol, 16'h0000);
        cfg_wr(a_mode, 16'h0004);
        irq_in = 4'b0100;
        tick(); tick();
        ack_valid = 1'b1; ack_id = 2'd2;
        tick();
        ack_valid = 1'b0;
        check("set_beats_ack", 16'(ext_int), 16'h0004);
        ack_valid = 1'b1;
        tick();
        ack_valid = 1'b0;
        check("ack2_clear", 16'(ext_int), 16'h0000);
        irq_in = 4'b0000;
        repeat (3) tick();
        irq_in = 4'b0100;
        tick(); tick();
        cfg_wr(a_pend, 16'h0004);
        check("set_beats_w1c", 16'(ext_int), 16'h0004);
        cfg_wr(a_pend, 16'h0004);
        check("w1c2_clear", 16'(ext_int), 16'h0000);

        // FORCE, mode change clearing, polarity change without spurious edge
        irq_in = 4'b0000;
        repeat (3) tick();
        cfg_wr(a_force, 16'h0004);
        check("force_edge", 16'(ext_int), 16'h0004);
        cfg_rd(a_force);
        check("force_reads0", cfg_rdata, 16'h0000);
        cfg_rd(a_pend);
        check("force_pend", cfg_rdata, 16'h0004);
        cfg_wr(a_mode, 16'h0000);
        check("mode_chg_ext", 16'(ext_int), 16'h0000);
        cfg_rd(a_pend);
        check("mode_chg_pend", cfg_rdata, 16'h0000);
        cfg_wr(a_force, 16'h0004);
        check("force_level", 16'(ext_int), 16'h0000);
        cfg_rd(a_pend);
        check("force_level_pend", cfg_rdata, 16'h0000);
        cfg_wr(a_mode, 16'h0004);
        cfg_wr(a_pol, 16'h0004);
        repeat (3) tick();
        check("pol_no_spurious", 16'(ext_int), 16'h0000);
        cfg_wr(a_pol, 16'h0000);

        // Simultaneous read and write returns the old value; upper bits masked
        cfg_read = 1'b1; cfg_write = 1'b1; cfg_addr = a_mode; cfg_wdata = 16'hFFF2;
        tick();
        cfg_read = 1'b0; cfg_write = 1'b0;
        check("rw_old", cfg_rdata, 16'h0004);
        cfg_rd(a_mode);
        check("mode_mask", cfg_rdata, 16'h0002);

        // Enable gating and asynchronous reset
        enable = 1'b0;
        irq_in = 4'b0010;
        repeat (5) tick();
        check("disabled_hold", 16'(ext_int), 16'h0000);
        enable = 1'b1;
        tick();
        check("enable_edge", 16'(ext_int), 16'h0002);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 16'(ext_int), 16'h0000);
        tick();
        check("reset_rdata2", cfg_rdata, 16'h0000);
        reset = 1'b0;
        cfg_rd(a_mode);
        check("reset_mode", cfg_rdata, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
